// File: rtl/sparc_pkg.sv
// rtl/sparc_pkg.sv - shared constants and types for the SPARC fetch stage
package sparc_pkg;

   localparam int          WORD_W      = 32;
   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam logic [31:0] NOP_WORD    = 32'h0100_0000;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
      logic              valid;
   } if_id_t;

   // Trap vectors are not checked for alignment; the low bits are simply dropped.
   function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
      return a & ~(INSTR_BYTES - 32'd1);
   endfunction

endpackage

// File: rtl/sparc_fetch_stage_if.sv
// rtl/sparc_fetch_stage_if.sv - instruction memory bus between fetch and imem
interface sparc_fetch_stage_if #(
   parameter int IMEM_AW = 6
);
   import sparc_pkg::*;

   logic [IMEM_AW-1:0] imem_addr;
   logic [WORD_W-1:0]  imem_rdata;

   modport master (output imem_addr, input imem_rdata);
   modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/sparc_fetch_stage_if_id_reg.sv
// rtl/sparc_fetch_stage_if_id_reg.sv - IF/ID pipeline register with enable and bubble flush
module if_id_reg
   import sparc_pkg::*;
#(
   parameter logic [WORD_W-1:0] BUBBLE_WORD = 32'h0100_0000
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   en,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   // Flush wins over enable; the bubble still records the PC it replaced.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '{instr: BUBBLE_WORD, pc: '0, valid: 1'b0};
      end else if (flush) begin
         q <= '{instr: BUBBLE_WORD, pc: d.pc, valid: 1'b0};
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/sparc_fetch_stage.sv
// rtl/sparc_fetch_stage.sv - SPARC PC/nPC fetch stage with delayed branch, annul, trap and fault
module sparc_fetch_stage
   import sparc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 6,
   parameter logic [31:0] NOP_WORD = sparc_pkg::NOP_WORD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                br_taken,
   input  logic                br_annul,
   input  logic [31:0]         br_target,
   input  logic                trap_req,
   input  logic [31:0]         trap_vec,
   sparc_fetch_stage_if.master imem,
   output logic [31:0]         pc,
   output logic [31:0]         npc,
   output logic [31:0]         if_id_instr,
   output logic [31:0]         if_id_pc,
   output logic                if_id_valid,
   output logic                fetch_fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, npc_q, pc_d, npc_d;
   logic [31:0]  trap_pc;
   logic         ifid_en, ifid_flush;
   if_id_t       ifid_d, ifid_q;

   assign trap_pc = align_word(trap_vec);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_PC + INSTR_BYTES;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      npc_d      = npc_q;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      ifid_d     = '{instr: imem.imem_rdata, pc: pc_q, valid: 1'b1};
      case (state_q)
         RUN: begin
            if (trap_req) begin
               pc_d       = trap_pc;
               npc_d      = trap_pc + INSTR_BYTES;
               ifid_flush = 1'b1;
            end else if (stall) begin
               // decode re-presents any branch once the stall clears
               ifid_en = 1'b0;
            end else if (br_taken && (br_target[1:0] != 2'b00)) begin
               state_d    = FAULT;
               ifid_flush = 1'b1;
            end else if (br_taken) begin
               // the word at pc is the delay slot; annul kills it in place
               ifid_en = 1'b1;
               if (br_annul) begin
                  ifid_d.instr = NOP_WORD;
                  ifid_d.valid = 1'b0;
               end
               pc_d  = br_target;
               npc_d = br_target + INSTR_BYTES;
            end else begin
               ifid_en = 1'b1;
               pc_d    = npc_q;
               npc_d   = npc_q + INSTR_BYTES;
            end
         end
         FAULT: begin
            ifid_flush = 1'b1;
         end
      endcase
   end

   if_id_reg #(
      .BUBBLE_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .en    (ifid_en),
      .flush (ifid_flush),
      .d     (ifid_d),
      .q     (ifid_q)
   );

   assign imem.imem_addr = pc_q[IMEM_AW+1:2];
   assign pc             = pc_q;
   assign npc            = npc_q;
   assign if_id_instr    = ifid_q.instr;
   assign if_id_pc       = ifid_q.pc;
   assign if_id_valid    = ifid_q.valid;
   assign fetch_fault    = (state_q == FAULT);

endmodule
